// File: rtl/pin_seq_pkg.sv
// Shared types for the pin sequencer: pattern modes and controller states.
package pin_seq_pkg;

    typedef enum logic [1:0] {
        MODE_BIN  = 2'd0,
        MODE_WALK = 2'd1,
        MODE_GRAY = 2'd2,
        MODE_HOLD = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_prescaler.sv
// Free-running prescaler: counts enabled cycles and strobes hit once the count reaches div.
module seq_prescaler #(
    parameter int DIV_W = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             hit
);

    localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

    logic [DIV_W-1:0] cnt;

    // >= rather than == so a div lowered below the running count fires on the next cycle
    assign hit = en && !clr && (cnt >= div);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= hit ? '0 : cnt + ONE;
        end
    end

endmodule

// File: rtl/pin_sequencer.sv
// Drives a binary / walking-one / Gray pattern on the pins, one step per prescaler tick,
// then stops after a step limit and drops the oscillator enable.
//   state   | meaning
//   ST_IDLE | counters and pins cleared, waiting for run
//   ST_RUN  | prescaler counting, pattern steps on each tick
//   ST_DONE | step limit reached, pins frozen, clk_en low
module pin_sequencer
    import pin_seq_pkg::*;
#(
    parameter int PINS    = 8,
    parameter int DIV_W   = 21,
    parameter int STEPS_W = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               restart,
    input  logic [1:0]         mode,
    input  logic [DIV_W-1:0]   div,
    input  logic [STEPS_W-1:0] steps,
    output logic [PINS-1:0]    pins,
    output logic               tick,
    output logic               done,
    output logic               clk_en
);

    localparam logic [PINS-1:0]    PIN_ONE  = PINS'(1);
    localparam logic [STEPS_W-1:0] STEP_ONE = STEPS_W'(1);

    state_e              state;
    state_e              state_nxt;
    logic [PINS-1:0]     bin;
    logic [PINS-1:0]     bin_inc;
    logic [PINS-1:0]     pat_nxt;
    logic [STEPS_W-1:0]  step_cnt;
    logic [STEPS_W-1:0]  step_inc;
    logic                step;
    logic                last_step;
    logic                pre_en;
    logic                pre_clr;

    assign pre_en  = (state == ST_RUN) && run;
    assign pre_clr = restart || (state != ST_RUN);

    seq_prescaler #(
        .DIV_W (DIV_W)
    ) u_pre (
        .clk (clk),
        .rst (rst),
        .en  (pre_en),
        .clr (pre_clr),
        .div (div),
        .hit (step)
    );

    assign bin_inc   = bin + PIN_ONE;
    assign step_inc  = step_cnt + STEP_ONE;
    assign last_step = step && (steps != '0) && (step_inc == steps);

    always_comb begin
        pat_nxt = pins;
        case (mode_e'(mode))
            MODE_BIN:  pat_nxt = bin_inc;
            MODE_WALK: pat_nxt = (pins == '0) ? PIN_ONE : {pins[PINS-2:0], pins[PINS-1]};
            MODE_GRAY: pat_nxt = bin_inc ^ (bin_inc >> 1);
            MODE_HOLD: pat_nxt = pins;
            default:   pat_nxt = pins;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (run) state_nxt = ST_RUN;
                ST_RUN:  if (last_step) state_nxt = ST_DONE;
                ST_DONE: state_nxt = ST_DONE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin      <= '0;
            pins     <= '0;
            step_cnt <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
            clk_en   <= 1'b1;
        end else if (restart) begin
            bin      <= '0;
            pins     <= '0;
            step_cnt <= '0;
            tick     <= 1'b0;
            done     <= 1'b0;
            clk_en   <= 1'b1;
        end else begin
            tick <= step;
            if (step) begin
                bin      <= bin_inc;
                pins     <= pat_nxt;
                step_cnt <= step_inc;
            end
            // done/clk_en follow the DONE state one cycle later, after the final tick
            if (state == ST_DONE) begin
                done   <= 1'b1;
                clk_en <= 1'b0;
            end
        end
    end

endmodule
